// File: rtl/change_dispenser.sv
// Purchase back-end: releases the product, then pays change greedily in 4/2/1 coins,
// each step through a 4-phase req/ack handshake. Optional macro ACK_TIMEOUT_EN adds a
// per-state ack watchdog with a sticky error flag.
module change_dispenser #(
  parameter int CAMBIO_W    = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                listo,
  input  logic [1:0]          producto,
  input  logic [CAMBIO_W-1:0] cambio,
  output logic                busy,
  output logic                vend_req,
  output logic [1:0]          vend_sel,
  input  logic                vend_ack,
  output logic                coin_req,
  output logic [1:0]          coin_sel,
  input  logic                coin_ack,
  output logic                done,
  output logic                error
);
  typedef enum logic [2:0] {IDLE, VEND, VEND_REL, CHANGE, COIN_REL, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          prod_q, prod_d;
  logic [CAMBIO_W-1:0] rem_q, rem_d, coin_val;
  logic                busy_q, busy_d, vend_req_q, vend_req_d, coin_req_q, coin_req_d;
  logic [1:0]          vend_sel_q, vend_sel_d, coin_sel_q, coin_sel_d;
  logic                done_q, done_d;
  logic                timeout, abort;

`ifdef ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;

  // Fires on the TIMEOUT_CYC-th cycle spent waiting in the same state.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign error   = error_q;

  always_comb begin
    cnt_d   = '0;
    if (state_d == state_q &&
        (state_q == VEND || state_q == VEND_REL || state_q == CHANGE || state_q == COIN_REL))
      cnt_d = cnt_q + 1'b1;
    error_d = error_q | abort;
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    case (coin_sel_q)
      2'b11:   coin_val = CAMBIO_W'(4);
      2'b10:   coin_val = CAMBIO_W'(2);
      default: coin_val = CAMBIO_W'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (listo && producto != 2'b00) begin
        state_d = VEND;
        prod_d  = producto;
        rem_d   = cambio;
      end
      VEND:
        if (vend_ack)     state_d = VEND_REL;
        else if (timeout) abort   = 1'b1;
      VEND_REL:
        if (!vend_ack)    state_d = (rem_q != '0) ? CHANGE : DONE;
        else if (timeout) abort   = 1'b1;
      CHANGE:
        if (coin_ack) begin
          rem_d   = rem_q - coin_val;
          state_d = COIN_REL;
        end else if (timeout) abort = 1'b1;
      COIN_REL:
        if (!coin_ack)    state_d = (rem_q != '0) ? CHANGE : DONE;
        else if (timeout) abort   = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    busy_d     = (state_d != IDLE);
    vend_req_d = (state_d == VEND);
    vend_sel_d = (state_d == VEND) ? prod_d : 2'b00;
    coin_req_d = (state_d == CHANGE);
    coin_sel_d = 2'b00;
    if (state_d == CHANGE) begin
      if (rem_d >= CAMBIO_W'(4))      coin_sel_d = 2'b11;
      else if (rem_d >= CAMBIO_W'(2)) coin_sel_d = 2'b10;
      else                            coin_sel_d = 2'b01;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prod_q     <= 2'b00;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      vend_req_q <= 1'b0;
      vend_sel_q <= 2'b00;
      coin_req_q <= 1'b0;
      coin_sel_q <= 2'b00;
      done_q     <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      cnt_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      vend_req_q <= vend_req_d;
      vend_sel_q <= vend_sel_d;
      coin_req_q <= coin_req_d;
      coin_sel_q <= coin_sel_d;
      done_q     <= done_d;
`ifdef ACK_TIMEOUT_EN
      cnt_q      <= cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign vend_req = vend_req_q;
  assign vend_sel = vend_sel_q;
  assign coin_req = coin_req_q;
  assign coin_sel = coin_sel_q;
  assign done     = done_q;
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the vending FSM. Consumes its one-cycle purchase result (listo, producto, cambio) and drives the product-release motor and the coin hopper through 4-phase req/ack handshakes. Change is paid greedily in 4/2/1 coins. Signals busy upstream and pulses done when the transaction completes.

Parameters:
CAMBIO_W, 5, width of cambio input and internal remaining-change register
TIMEOUT_CYC, 255, max cycles waiting on any ack edge (used only with ACK_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
listo  input  1  purchase-valid strobe from vending FSM
producto  input  2  product code (01=A, 10=B, 11=C, 00=none)
cambio  input  CAMBIO_W  change owed, unsigned units
busy  output  1  high in every state except IDLE
vend_req  output  1  product-release request to motor
vend_sel  output  2  product code for motor, valid while vend_req=1
vend_ack  input  1  motor acknowledge
coin_req  output  1  coin-eject request to hopper
coin_sel  output  2  coin type: 01=1 unit, 10=2 units, 11=4 units
coin_ack  input  1  hopper acknowledge
done  output  1  one-cycle pulse at transaction end
error  output  1  sticky handshake-timeout flag

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low. All outputs registered.
- Reset: state=IDLE; busy, vend_req, vend_sel, coin_req, coin_sel, done, error = 0; internal prod_r, rem = 0. Assertion mid-transaction drops all requests immediately (asynchronous); the transaction is abandoned with no resume.
- States: IDLE, VEND, VEND_REL, CHANGE, COIN_REL, DONE.
- IDLE: at a rising edge with listo=1 and producto!=00, latch prod_r=producto and rem=cambio, go to VEND. vend_req=1 is visible the cycle after listo is sampled. listo with producto=00 is ignored.
- listo while busy=1 is ignored; the latched transaction is unaffected.
- VEND: vend_req=1, vend_sel=prod_r. On the edge sampling vend_ack=1, go to VEND_REL; vend_req=0 from the next cycle.
- VEND_REL: wait for vend_ack=0. Then go to CHANGE if rem!=0, else DONE.
- CHANGE: coin_req=1. coin_sel=11 if rem>=4, else 10 if rem>=2, else 01. coin_sel stays stable while coin_req=1. On the edge sampling coin_ack=1: rem <= rem - coin value (never underflows, by greedy rule), go to COIN_REL.
- COIN_REL: wait for coin_ack=0. Then go to CHANGE if rem!=0, else DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. A back-to-back listo is accepted at the earliest on the first IDLE cycle.
- Ack levels sampled outside their wait state are ignored. vend_ack=1 already high on entry to VEND counts as an acknowledge.
- Coin count per transaction = floor(rem/4) + popcount(rem mod 4). Coins are issued in non-increasing value order.
- error is cleared only by reset.

Optional Feature:
Macro ACK_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every state change and increments in VEND, VEND_REL, CHANGE and COIN_REL.
  - When it reaches TIMEOUT_CYC without the awaited ack transition: next cycle vend_req=0, coin_req=0, error=1 (sticky), state=IDLE, no done pulse, rem discarded.
- Undefined: no counter logic; handshakes wait indefinitely; error tied to 0.

Test Plan:
1. listo=1, producto=01, cambio=0; vend_ack rises 3 cycles after vend_req, falls 2 later -> vend_sel=01, no coin_req, single done pulse, busy low next cycle.
2. producto=11, cambio=7; hopper acks each req after 2 cycles -> coin_sel sequence 11,10,01 (three handshakes), then done.
3. producto=10, cambio=13 -> coin_sel 11,11,11,01; rem reaches 0; done once.
4. listo during CHANGE with a new producto/cambio, and listo with producto=00 in IDLE -> both ignored; coin sequence and vend_sel of the original transaction unchanged.
5. rst_n driven low between edges while coin_req=1 -> coin_req, busy, vend_req go 0 without a clock edge; after release the block is in IDLE and accepts a new listo normally.
6. ACK_TIMEOUT_EN defined, TIMEOUT_CYC=8, vend_ack held 0 -> vend_req drops after 8 wait cycles, error=1, busy=0, no done; error stays 1 through a later good transaction until reset.
